pipelined_adder: RTL and testbench

- Parametrised, pipelined N-bit adder; successor to the single-bit combinational half adder.
- Splits a WIDTH-bit add with carry-in into STAGES equal segments, one segment per clock, registering the carry between segments.
- Streams operands through a valid/ready handshake at one result per cycle, and reports carry-out and signed overflow.
- Arithmetic leaf used by datapath blocks of the verification platform.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_segment.sv | 19 +
 rtl/pipelined_adder.sv | 99 +++++++++
 tb/tb_pipelined_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, segment sizing
// and the stage record layout for the default configuration.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic [DEFAULT_WIDTH-1:0] opa;
    logic [DEFAULT_WIDTH-1:0] opb;
    logic                     carry;
    logic                     ovf;
  } stage_default_t;

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit full adder returning {cout, carry_into_msb, sum}.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG+1:0] o_res
);

  logic [SEG:0] w_full;
  logic         w_cmsb;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out by XOR.
  assign w_cmsb = w_full[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];
  assign o_res  = {w_full[SEG], w_cmsb, w_full[SEG-1:0]};

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-registered segments, one segment per
// clock, with a globally stalled valid/ready pipeline.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic             ovf;
  } stage_t;

  stage_t         r_stage [STAGES];
  stage_t         w_src   [STAGES];
  stage_t         w_nxt   [STAGES];
  logic [SEG+1:0] w_res   [STAGES];
  logic           w_adv;

  assign w_adv    = !r_stage[STAGES-1].valid || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_src[0]       = '0;
    w_src[0].valid = in_valid;
    w_src[0].opa   = A;
    w_src[0].opb   = B;
    w_src[0].carry = Cin;
    for (int k = 1; k < STAGES; k++) begin
      w_src[k] = r_stage[k-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
    adder_segment #(.SEG(SEG)) u_seg (
      .i_a   (w_src[gi].opa[gi*SEG +: SEG]),
      .i_b   (w_src[gi].opb[gi*SEG +: SEG]),
      .i_cin (w_src[gi].carry),
      .o_res (w_res[gi])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k]                     = w_src[k];
      w_nxt[k].sum[k*SEG +: SEG]   = w_res[k][SEG-1:0];
      w_nxt[k].carry               = w_res[k][SEG+1];
      w_nxt[k].ovf                 = w_res[k][SEG+1] ^ w_res[k][SEG];
    end
  end

  // Payload only loads with a valid beat so the outputs keep the last result
  // while bubbles flow through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_nxt[k].valid) begin
          r_stage[k] <= w_nxt[k];
        end else begin
          r_stage[k].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_stage[STAGES-1].valid;
  assign S         = r_stage[STAGES-1].sum;
  assign Cout      = r_stage[STAGES-1].carry;
  assign Ovf       = r_stage[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks of pipelined_adder (WIDTH=16, STAGES=4)
// against hand-computed vectors and a cycle-level shift-register model.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        Ovf;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: four pipeline slots plus the held output word {ovf, cout, sum}.
  logic        m_v [4];
  logic [17:0] m_d [4];
  logic [17:0] m_out;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_res(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t[16], t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_out = '0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic ordy);
    logic adv;
    in_valid  = v;
    A         = a;
    B         = b;
    Cin       = ci;
    out_ready = ordy;
    #1;
    adv = !m_v[3] || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, adv});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_v[3]});
    chk("S", {16'd0, S}, {16'd0, m_out[15:0]});
    chk("Cout", {31'd0, Cout}, {31'd0, m_out[16]});
    chk("Ovf", {31'd0, Ovf}, {31'd0, m_out[17]});
    @(posedge clk);
    if (adv) begin
      if (m_v[2]) m_out = m_d[2];
      for (int i = 3; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_d[i] = m_d[i-1];
      end
      m_v[0] = v;
      m_d[0] = exp_res(a, b, ci);
    end
    #1;
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo);
    cycle(1'b1, a, b, ci, 1'b1);
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk("early_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("hand_S", {16'd0, S}, {16'd0, es});
    chk("hand_Cout", {31'd0, Cout}, {31'd0, ec});
    chk("hand_Ovf", {31'd0, Ovf}, {31'd0, eo});
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_S", {16'd0, S}, 32'd0);
    chk("rst_Cout", {31'd0, Cout}, 32'd0);
    chk("rst_Ovf", {31'd0, Ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    single(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    single(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    single(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Back-to-back streaming
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      cycle(1'b1, ra, rb, rc, 1'b1);
    end
    repeat (6) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

    // Fill with out_ready low, then stall five cycles with a beat waiting
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    cycle(1'b1, 16'h8001, 16'h8001, 1'b1, 1'b0);
    cycle(1'b1, 16'h7000, 16'h1000, 1'b0, 1'b0);
    cycle(1'b1, 16'hABCD, 16'h5432, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0F0F, 16'hF0F1, 1'b0, 1'b1);
    cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1);
    cycle(1'b1, 16'hC000, 16'hBFFF, 1'b0, 1'b0);
    cycle(1'b1, 16'hC000, 16'hBFFF, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

    // Reset with three beats in flight
    cycle(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b1);
    cycle(1'b1, 16'h0506, 16'h0708, 1'b1, 1'b1);
    cycle(1'b1, 16'h090A, 16'h0B0C, 1'b0, 1'b1);
    in_valid = 1'b1;
    do_reset();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_S", {16'd0, S}, 32'd0);
    chk("mid_rst_Cout", {31'd0, Cout}, 32'd0);
    chk("mid_rst_Ovf", {31'd0, Ovf}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    single(16'h2468, 16'h1357, 1'b1, 16'h37C0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
